// File: rtl/pipe_mmio_ctrl_pkg.sv
// pipe_mmio_ctrl_pkg: register offsets and default window base for the MEM-stage I/O controller
package pipe_mmio_ctrl_pkg;
  localparam logic [7:0] IO_IN_OFS = 8'h00;
  localparam logic [7:0] IO_OUT_OFS = 8'h40;
  localparam logic [7:0] IO_CHG_OFS = 8'h80;
  localparam logic [7:0] IO_IEN_OFS = 8'h84;
  localparam logic [31:0] IO_BASE_DEF = 32'h0000_0080;
endpackage

// File: rtl/io_sync2.sv
// io_sync2: two-flop synchroniser with synchronous reset
module io_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q, sync_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end
  assign q_o = sync_q;
endmodule

// File: rtl/pipe_mmio_ctrl.sv
// pipe_mmio_ctrl: MEM-stage memory-mapped I/O with synced inputs, output registers,
// W1C change flags and a maskable irq
module pipe_mmio_ctrl
  import pipe_mmio_ctrl_pkg::*;
#(
  parameter int          N_IN    = 2,
  parameter int          IN_W    = 4,
  parameter int          N_OUT   = 1,
  parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 rd_en_i,
  input  logic                 wr_en_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  output logic                 hit_o,
  output logic [31:0]          rdata_o,
  input  logic [N_IN*IN_W-1:0] in_ports_i,
  output logic [N_OUT*32-1:0]  out_ports_o,
  output logic                 irq_o
);
  logic [N_IN*IN_W-1:0] in_sync, prev_q;
  logic [N_IN-1:0] chg_ev, status_q, status_d, ien_q, ien_d;
  logic [N_OUT*32-1:0] out_q;
  logic [31:0] in_word [16];
  logic [31:0] out_word [16];
  logic [31:0] rd_val, rdata_q, rdata_d;
  logic [7:0] ofs;
  logic rd, wr, irq_q, irq_d;

  assign hit_o = addr_i[31:8] == IO_BASE[31:8];
  assign ofs = addr_i[7:0] & 8'hFC;
  assign rd = rd_en_i & hit_o;
  assign wr = wr_en_i & hit_o;

  io_sync2 #(.WIDTH(N_IN*IN_W)) u_sync (
    .clk_i(clock_i),
    .rst_i(reset_i),
    .d_i  (in_ports_i),
    .q_o  (in_sync)
  );

  // Tables are padded to 16 entries so out-of-range offsets read zero
  for (genvar i = 0; i < 16; i++) begin : g_in
    if (i < N_IN) begin : g_v
      assign in_word[i] = 32'(in_sync[i*IN_W +: IN_W]);
      assign chg_ev[i] = |(in_sync[i*IN_W +: IN_W] ^ prev_q[i*IN_W +: IN_W]);
    end else begin : g_z
      assign in_word[i] = '0;
    end
  end

  for (genvar j = 0; j < 16; j++) begin : g_out
    if (j < N_OUT) begin : g_v
      assign out_word[j] = out_q[j*32 +: 32];
    end else begin : g_z
      assign out_word[j] = '0;
    end
  end

  // A change event ORed in last so it beats a coincident W1C clear
  always_comb begin
    status_d = (status_q & ~((wr && ofs == IO_CHG_OFS) ? wdata_i[N_IN-1:0] : '0)) | chg_ev;
    ien_d = (wr && ofs == IO_IEN_OFS) ? wdata_i[N_IN-1:0] : ien_q;
    irq_d = |(status_d & ien_d);
    rd_val = (ofs[7:6] == IO_IN_OFS[7:6])  ? in_word[ofs[5:2]] :
             (ofs[7:6] == IO_OUT_OFS[7:6]) ? out_word[ofs[5:2]] :
             (ofs == IO_CHG_OFS)           ? 32'(status_q) :
             (ofs == IO_IEN_OFS)           ? 32'(ien_q) : '0;
    rdata_d = rd ? rd_val : rdata_q;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      prev_q <= '0;
      status_q <= '0;
      ien_q <= '0;
      irq_q <= 1'b0;
      rdata_q <= '0;
      out_q <= '0;
    end else begin
      prev_q <= in_sync;
      status_q <= status_d;
      ien_q <= ien_d;
      irq_q <= irq_d;
      rdata_q <= rdata_d;
      for (int j = 0; j < N_OUT; j++)
        if (wr && ofs == IO_OUT_OFS + 8'(4*j)) out_q[j*32 +: 32] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;
  assign out_ports_o = out_q;
  assign irq_o = irq_q;
endmodule

// File: tb/tb_pipe_mmio_ctrl.sv
// tb_pipe_mmio_ctrl: scoreboard bench over a default instance and a wide (4x8 in, 3 out) instance
module tb_pipe_mmio_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_a_nx = 1'b1, rst_b_nx = 1'b1;
  logic rd_a = 1'b0, wr_a = 1'b0, rd_b = 1'b0, wr_b = 1'b0;
  logic [31:0] addr_a = '0, wdata_a = '0, addr_b = '0, wdata_b = '0;
  logic [7:0] in_a = '0, in_a_nx = '0;
  logic [31:0] in_b = '0, in_b_nx = '0;
  logic hit_a, hit_b, irq_a, irq_b;
  logic [31:0] rdata_a, rdata_b, out_a;
  logic [95:0] out_b;

  pipe_mmio_ctrl u_a (
    .clock_i(clk), .reset_i(rst_a), .rd_en_i(rd_a), .wr_en_i(wr_a),
    .addr_i(addr_a), .wdata_i(wdata_a), .hit_o(hit_a), .rdata_o(rdata_a),
    .in_ports_i(in_a), .out_ports_o(out_a), .irq_o(irq_a)
  );

  pipe_mmio_ctrl #(.N_IN(4), .IN_W(8), .N_OUT(3)) u_b (
    .clock_i(clk), .reset_i(rst_b), .rd_en_i(rd_b), .wr_en_i(wr_b),
    .addr_i(addr_b), .wdata_i(wdata_b), .hit_o(hit_b), .rdata_o(rdata_b),
    .in_ports_i(in_b), .out_ports_o(out_b), .irq_o(irq_b)
  );

  typedef struct {
    int s;
    logic [95:0] v;
    string n;
  } exp_t;
  exp_t q[$];
  int passed = 0, total = 0;

  task automatic step(input int u, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rst_a = rst_a_nx;
    rst_b = rst_b_nx;
    in_a = in_a_nx;
    in_b = in_b_nx;
    rd_a = (u == 0) && r;
    wr_a = (u == 0) && w;
    addr_a = (u == 0) ? a : '0;
    wdata_a = (u == 0) ? d : '0;
    rd_b = (u == 1) && r;
    wr_b = (u == 1) && w;
    addr_b = (u == 1) ? a : '0;
    wdata_b = (u == 1) ? d : '0;
  endtask

  task automatic ex(input int s, input logic [95:0] v, input string n);
    q.push_back('{s, v, n});
  endtask

  // Expectations pushed before an edge are checked just after it
  initial begin
    exp_t e;
    logic [95:0] act;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        act = (e.s == 0) ? {64'b0, rdata_a} :
              (e.s == 1) ? {64'b0, out_a} :
              (e.s == 2) ? {95'b0, irq_a} :
              (e.s == 3) ? {95'b0, hit_a} :
              (e.s == 4) ? {64'b0, rdata_b} :
              (e.s == 5) ? out_b : {95'b0, irq_b};
        total++;
        if (act === e.v) passed++;
        else $display("FAIL %s: got %h expected %h", e.n, act, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    ex(0, 0, "rst_rdata"); ex(1, 0, "rst_out"); ex(2, 0, "rst_irq");
    ex(4, 0, "rst_rdata_b"); ex(5, 0, "rst_out_b");
    rst_a_nx = 1'b0; rst_b_nx = 1'b0;
    step(0, 1, 0, 32'h80, 0); ex(0, 0, "rst_chg"); ex(3, 1, "hit_in");
    step(0, 0, 1, 32'h40, 32'hDEAD_BEEF); ex(1, 32'hDEAD_BEEF, "out_wr");
    step(0, 1, 0, 32'h40, 0); ex(0, 32'hDEAD_BEEF, "out_rd");
    in_a_nx = 8'h09;
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h00, 0); ex(0, 0, "sync_e1");
    step(0, 1, 0, 32'h00, 0); ex(0, 9, "sync_e2");
    step(0, 1, 0, 32'h80, 0); ex(0, 1, "chg_e3"); ex(2, 0, "irq_masked");
    step(0, 0, 1, 32'h80, 1);
    step(0, 0, 1, 32'h84, 3); ex(2, 0, "irq_en_no_pend");
    step(0, 1, 0, 32'h84, 0); ex(0, 3, "ien_rd");
    in_a_nx = 8'h19;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0); ex(2, 0, "irq_e1");
    step(0, 0, 0, 0, 0); ex(2, 1, "irq_set");
    step(0, 0, 1, 32'h80, 2); ex(2, 0, "irq_clr");
    step(0, 1, 0, 32'h80, 0); ex(0, 0, "chg_clr");
    in_a_nx = 8'h09;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h80, 2); ex(2, 1, "set_wins_irq");
    step(0, 1, 0, 32'h80, 0); ex(0, 2, "set_wins_st");
    step(0, 0, 1, 32'h80, 2); ex(2, 0, "irq_clr2");
    step(0, 1, 0, 32'h40, 0); ex(0, 32'hDEAD_BEEF, "out_rd2");
    step(0, 1, 1, 32'h180, 32'h1234_5678);
    ex(3, 0, "hit_out"); ex(0, 32'hDEAD_BEEF, "miss_rd_hold"); ex(1, 32'hDEAD_BEEF, "miss_wr");
    step(0, 0, 1, 32'h00, 32'hFF);
    step(0, 1, 0, 32'h00, 0); ex(0, 9, "ro_wr");
    step(0, 1, 0, 32'h7C, 0); ex(0, 0, "rd_7c");
    step(0, 1, 0, 32'h44, 0); ex(0, 0, "rd_44");
    step(0, 1, 0, 32'h88, 0); ex(0, 0, "rd_88");
    step(0, 1, 1, 32'h40, 32'hCAFE_F00D);
    ex(0, 32'hDEAD_BEEF, "rbw_rd"); ex(1, 32'hCAFE_F00D, "rbw_out");
    step(0, 1, 0, 32'h40, 0); ex(0, 32'hCAFE_F00D, "rbw_after");
    step(0, 0, 1, 32'h84, 32'hFFFF_FFFF);
    step(0, 1, 0, 32'h84, 0); ex(0, 3, "ien_upper");
    rst_a_nx = 1'b1;
    step(0, 0, 0, 0, 0); ex(0, 0, "rst2_rdata"); ex(1, 0, "rst2_out"); ex(2, 0, "rst2_irq");
    rst_a_nx = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h00, 0); ex(0, 0, "rst_in_e1");
    step(0, 1, 0, 32'h80, 0); ex(0, 0, "rst_chg_e2");
    step(0, 1, 0, 32'h80, 0); ex(0, 1, "rst_chg_e3");
    step(1, 0, 1, 32'h40, 32'h1111_1111);
    step(1, 0, 1, 32'h44, 32'h2222_2222);
    step(1, 0, 1, 32'h48, 32'h3333_3333);
    ex(5, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, "b_out3");
    step(1, 1, 0, 32'h44, 0); ex(4, 32'h2222_2222, "b_rd44");
    rst_b_nx = 1'b1;
    step(1, 0, 1, 32'h48, 32'h4444_4444); ex(5, 0, "b_rst_mid_wr"); ex(4, 0, "b_rst_rdata");
    rst_b_nx = 1'b0;
    in_b_nx = 32'hA1B2_C3D4;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 32'h00, 0); ex(4, 32'hD4, "b_in0");
    step(1, 1, 0, 32'h04, 0); ex(4, 32'hC3, "b_in1");
    step(1, 1, 0, 32'h08, 0); ex(4, 32'hB2, "b_in2");
    step(1, 1, 0, 32'h0C, 0); ex(4, 32'hA1, "b_in3");
    step(1, 1, 0, 32'h10, 0); ex(4, 0, "b_in4");
    step(1, 1, 0, 32'h80, 0); ex(4, 32'hF, "b_chg");
    step(1, 1, 0, 32'h48, 0); ex(4, 0, "b_out2_rst");
    step(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    if (q.size() > 0) begin
      $display("FAIL scoreboard: %0d expectations unchecked, required 0", q.size());
      total += q.size();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
